vga_note_lane: RTL and testbench

- One guitar-hero style lane of falling note rectangles, drawn over the VGA pixel scan next to the fret bars.
- Holds up to NUM_SLOTS notes. Each frame it moves every note down by SPEED. The game controller spawns notes through a valid/ready handshake.
- Judges strums against a hit window and reports hit and miss events to the scoring logic.
- Outputs a registered per-pixel "note here" flag that feeds the VGA colour mux.

---
 rtl/vga_game_pkg.sv | 13 +
 rtl/vga_note_lane_if.sv | 10 +
 rtl/vga_rect.sv | 24 ++
 rtl/vga_note_lane.sv | 156 +++++++++++++++
 tb/tb_vga_note_lane.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_game_pkg.sv
// Shared constants and helpers for the VGA game blocks.
package vga_game_pkg;

  localparam int COORD_WIDTH   = 10;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  // Width needed to hold a count from 0 up to and including n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vga_note_lane_if.sv
// Spawn handshake between the game controller and a note lane.
interface vga_note_lane_if;

  logic spawn_valid;
  logic spawn_ready;

  modport master (output spawn_valid, input spawn_ready);
  modport slave  (input spawn_valid, output spawn_ready);

endinterface

// File: rtl/vga_rect.sv
// Combinational test of whether (x, y) lies in a W x H rectangle at (x0, y0).
// Left/top edges are inclusive, right/bottom edges exclusive.
module vga_rect
  import vga_game_pkg::*;
#(
  parameter int COORD_W = COORD_WIDTH,
  parameter int W       = 20,
  parameter int H       = 8
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  output logic               in
);

  localparam logic [COORD_W:0] W_EXT = (COORD_W + 1)'(W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W + 1)'(H);

  // One extra bit keeps x0+W from wrapping near the screen edge.
  assign in = ({1'b0, x} >= {1'b0, x0}) && ({1'b0, x} < ({1'b0, x0} + W_EXT)) &&
              ({1'b0, y} >= {1'b0, y0}) && ({1'b0, y} < ({1'b0, y0} + H_EXT));

endmodule

// File: rtl/vga_note_lane.sv
// One lane of falling notes: spawn, per-frame advance, strum judging,
// miss reporting and a registered per-pixel note flag.
module vga_note_lane
  import vga_game_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int COORD_W   = COORD_WIDTH,
  parameter int LANE_X    = 100,
  parameter int NOTE_W    = 20,
  parameter int NOTE_H    = 8,
  parameter int SPEED     = 2,
  parameter int HIT_Y     = 400,
  parameter int HIT_WIN   = 10,
  parameter int SCREEN_H  = SCREEN_HEIGHT,
  localparam int CNT_W    = count_w(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  vga_note_lane_if.slave     lane,
  input  logic               strum,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               dispValOut,
  output logic               hit,
  output logic               miss,
  output logic [CNT_W-1:0]   miss_count,
  output logic [CNT_W-1:0]   active_count
);

  localparam logic signed [COORD_W+1:0] HALF_H_S = (COORD_W + 2)'(NOTE_H / 2);
  localparam logic signed [COORD_W+1:0] HIT_Y_S  = (COORD_W + 2)'(HIT_Y);
  localparam logic signed [COORD_W+1:0] WIN_S    = (COORD_W + 2)'(HIT_WIN);
  localparam logic [COORD_W:0]          SPEED_EXT  = (COORD_W + 1)'(SPEED);
  localparam logic [COORD_W:0]          SCREEN_EXT = (COORD_W + 1)'(SCREEN_H);
  localparam logic [COORD_W-1:0]        LANE_X_C   = COORD_W'(LANE_X);

  logic [NUM_SLOTS-1:0] valid, nxt_valid;
  logic [COORD_W-1:0]   top [NUM_SLOTS];
  logic [COORD_W-1:0]   nxt_top [NUM_SLOTS];
  logic [COORD_W:0]     adv [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] elig, rect_in, off_screen, hit_sel, free_sel;
  logic [COORD_W-1:0]   best_top;
  logic                 found, taken;
  int                   best_idx;
  logic [CNT_W-1:0]     miss_n, pop_n;

  assign lane.spawn_ready = |(~valid);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic signed [COORD_W+1:0] off;
    assign off           = $signed({2'b00, top[i]}) + HALF_H_S - HIT_Y_S;
    assign elig[i]       = valid[i] && (off >= -WIN_S) && (off <= WIN_S);
    assign adv[i]        = {1'b0, top[i]} + SPEED_EXT;
    assign off_screen[i] = adv[i] >= SCREEN_EXT;

    vga_rect #(.COORD_W(COORD_W), .W(NOTE_W), .H(NOTE_H)) u_rect (
      .x  (x),
      .y  (y),
      .x0 (LANE_X_C),
      .y0 (top[i]),
      .in (rect_in[i])
    );
  end

  // Pick the eligible note lowest on screen; strict '>' gives ties to the lowest index.
  always_comb begin
    found    = 1'b0;
    best_top = '0;
    best_idx = 0;
    hit_sel  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (elig[i] && (!found || top[i] > best_top)) begin
        found    = 1'b1;
        best_top = top[i];
        best_idx = i;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_sel[i] = strum && found && (best_idx == i);
    end
  end

  // Lowest free slot, judged on the valid bits before this cycle's clears.
  always_comb begin
    taken    = 1'b0;
    free_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!valid[i] && !taken) begin
        taken       = 1'b1;
        free_sel[i] = lane.spawn_valid;
      end
    end
  end

  // Next slot state: advance (skipping the hit note), clear the hit note, place a spawn.
  always_comb begin
    nxt_valid = valid;
    nxt_top   = top;
    miss_n    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (frame_tick && valid[i] && !hit_sel[i]) begin
        if (off_screen[i]) begin
          nxt_valid[i] = 1'b0;
          miss_n       = miss_n + CNT_W'(1);
        end else begin
          nxt_top[i] = adv[i][COORD_W-1:0];
        end
      end
      if (hit_sel[i]) begin
        nxt_valid[i] = 1'b0;
      end
      if (free_sel[i]) begin
        nxt_valid[i] = 1'b1;
        nxt_top[i]   = '0;
      end
    end
  end

  // Population count of the slots that will be valid after this cycle.
  always_comb begin
    pop_n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pop_n = pop_n + CNT_W'(nxt_valid[i]);
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) top[i] <= '0;
    end else begin
      valid <= nxt_valid;
      for (int i = 0; i < NUM_SLOTS; i++) top[i] <= nxt_top[i];
    end
  end

  // Registered pixel flag, event pulses and counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispValOut   <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      miss_count   <= '0;
      active_count <= '0;
    end else begin
      dispValOut   <= |(valid & rect_in);
      hit          <= |hit_sel;
      miss         <= frame_tick && (miss_n != '0);
      miss_count   <= frame_tick ? miss_n : '0;
      active_count <= pop_n;
    end
  end

endmodule

// File: tb/tb_vga_note_lane.sv
// Directed self-checking bench for vga_note_lane with default parameters.
module tb_vga_note_lane;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       strum;
  logic [9:0] x;
  logic [9:0] y;
  logic       disp;
  logic       hit;
  logic       miss;
  logic [3:0] miss_count;
  logic [3:0] active_count;
  int         tests = 0;
  int         failures = 0;

  vga_note_lane_if lane_if ();

  vga_note_lane dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .lane         (lane_if),
    .strum        (strum),
    .x            (x),
    .y            (y),
    .dispValOut   (disp),
    .hit          (hit),
    .miss         (miss),
    .miss_count   (miss_count),
    .active_count (active_count)
  );

  // 10 ns pixel clock.
  always #5 clk = ~clk;

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic spawnNote();
    lane_if.spawn_valid = 1'b1;
    applyStimulus(1);
    lane_if.spawn_valid = 1'b0;
  endtask

  task automatic runFrames(input int n);
    frame_tick = 1'b1;
    applyStimulus(n);
    frame_tick = 1'b0;
  endtask

  task automatic strumOnce();
    strum = 1'b1;
    applyStimulus(1);
    strum = 1'b0;
  endtask

  task automatic scanAt(input int xv, input int yv);
    x = 10'(xv);
    y = 10'(yv);
    applyStimulus(1);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    applyStimulus(1);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    strum = 1'b0;
    x = '0;
    y = '0;
    lane_if.spawn_valid = 1'b0;
    applyStimulus(2);
    checkOutput("reset_active", active_count, 0);
    checkOutput("reset_disp", disp, 0);
    checkOutput("reset_hit", hit, 0);
    checkOutput("reset_miss", miss, 0);
    checkOutput("reset_miss_count", miss_count, 0);
    checkOutput("reset_ready", lane_if.spawn_ready, 1);
    rst_n = 1'b1;
    applyStimulus(1);

    // Fill all eight slots back to back, then try a ninth.
    lane_if.spawn_valid = 1'b1;
    applyStimulus(7);
    checkOutput("fill7_active", active_count, 7);
    checkOutput("fill7_ready", lane_if.spawn_ready, 1);
    applyStimulus(1);
    checkOutput("fill8_active", active_count, 8);
    checkOutput("fill8_ready", lane_if.spawn_ready, 0);
    applyStimulus(1);
    checkOutput("ninth_ignored", active_count, 8);
    lane_if.spawn_valid = 1'b0;
    resetDut();
    checkOutput("cleared_active", active_count, 0);

    // Spawn together with frame_tick: note stays at top 0.
    lane_if.spawn_valid = 1'b1;
    frame_tick = 1'b1;
    applyStimulus(1);
    lane_if.spawn_valid = 1'b0;
    frame_tick = 1'b0;
    scanAt(100, 0);
    checkOutput("spawn_frame_top0", disp, 1);
    x = '0;
    y = '0;
    resetDut();

    // 200 frames at speed 2 puts the note at top 400.
    spawnNote();
    runFrames(200);
    checkOutput("move_active", active_count, 1);
    scanAt(100, 403);
    checkOutput("rect_inside", disp, 1);
    scanAt(120, 403);
    checkOutput("rect_right_edge", disp, 0);
    scanAt(119, 403);
    checkOutput("rect_right_in", disp, 1);
    scanAt(99, 403);
    checkOutput("rect_left_out", disp, 0);
    scanAt(100, 399);
    checkOutput("rect_above", disp, 0);
    scanAt(100, 400);
    checkOutput("rect_top_row", disp, 1);
    scanAt(100, 407);
    checkOutput("rect_bottom_row", disp, 1);
    scanAt(100, 408);
    checkOutput("rect_below", disp, 0);
    x = '0;
    y = '0;
    resetDut();

    // Hit window: 300 and 384 miss the window, 396 is centred.
    spawnNote();
    runFrames(150);
    strumOnce();
    checkOutput("strum300_hit", hit, 0);
    checkOutput("strum300_active", active_count, 1);
    runFrames(42);
    strumOnce();
    checkOutput("strum384_hit", hit, 0);
    runFrames(6);
    strumOnce();
    checkOutput("strum396_hit", hit, 1);
    checkOutput("strum396_active", active_count, 0);
    applyStimulus(1);
    checkOutput("hit_pulse_end", hit, 0);

    // Top 406 puts the centre exactly HIT_WIN below the strike line.
    spawnNote();
    runFrames(203);
    strumOnce();
    checkOutput("strum406_hit", hit, 1);
    checkOutput("strum406_active", active_count, 0);

    // Two eligible notes (396 and 394): the lower one goes first.
    spawnNote();
    runFrames(1);
    spawnNote();
    runFrames(197);
    strumOnce();
    checkOutput("prio_hit", hit, 1);
    checkOutput("prio_active", active_count, 1);
    scanAt(100, 402);
    checkOutput("prio_lower_gone", disp, 0);
    scanAt(100, 394);
    checkOutput("prio_upper_kept", disp, 1);
    strumOnce();
    checkOutput("prio_second_hit", hit, 1);
    checkOutput("prio_second_active", active_count, 0);
    x = '0;
    y = '0;

    // Two notes at 478 fall off together on the next frame.
    spawnNote();
    spawnNote();
    runFrames(239);
    checkOutput("pre_miss_active", active_count, 2);
    checkOutput("pre_miss_flag", miss, 0);
    runFrames(1);
    checkOutput("miss_flag", miss, 1);
    checkOutput("miss_count", miss_count, 2);
    checkOutput("miss_active", active_count, 0);
    applyStimulus(1);
    checkOutput("miss_pulse_end", miss, 0);
    checkOutput("miss_count_end", miss_count, 0);

    // Strum and frame_tick together with notes at 396 and 100.
    spawnNote();
    runFrames(148);
    spawnNote();
    runFrames(50);
    strum = 1'b1;
    frame_tick = 1'b1;
    applyStimulus(1);
    strum = 1'b0;
    frame_tick = 1'b0;
    checkOutput("combo_hit", hit, 1);
    checkOutput("combo_active", active_count, 1);
    scanAt(100, 102);
    checkOutput("combo_advanced_top", disp, 1);
    scanAt(100, 101);
    checkOutput("combo_above_moved", disp, 0);
    scanAt(100, 398);
    checkOutput("combo_hit_not_advanced", disp, 0);
    x = '0;
    y = '0;
    resetDut();

    // Asynchronous reset in the middle of a scan line with five notes.
    lane_if.spawn_valid = 1'b1;
    applyStimulus(5);
    lane_if.spawn_valid = 1'b0;
    scanAt(100, 3);
    checkOutput("five_disp", disp, 1);
    checkOutput("five_active", active_count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_disp", disp, 0);
    checkOutput("async_active", active_count, 0);
    checkOutput("async_ready", lane_if.spawn_ready, 1);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("post_reset_disp", disp, 0);
    runFrames(1);
    checkOutput("post_reset_miss", miss, 0);
    checkOutput("post_reset_active", active_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
